// File: rtl/joystick_sprite_if.sv
// Stick/control inputs and sprite outputs shared between the controller
// front-end (master) and the position integrator (slave).
interface joystick_sprite_if;
  logic [7:0] xstick;
  logic [7:0] ystick;
  logic       boost;
  logic       recenter;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] BallS;
  logic       moving;
  logic       hit_x;
  logic       hit_y;

  modport master (
    output xstick, ystick, boost, recenter,
    input  BallX, BallY, BallS, moving, hit_x, hit_y
  );

  modport slave (
    input  xstick, ystick, boost, recenter,
    output BallX, BallY, BallS, moving, hit_x, hit_y
  );
endinterface

// File: rtl/joystick_sprite.sv
// Per-frame sprite position integrator: stick offsets -> deadzone/scaled steps
// with boost and hold-acceleration, integrated with clamp or wrap edges.
module joystick_sprite #(
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int X_CENTER     = 320,
  parameter int Y_CENTER     = 240,
  parameter int SIZE         = 4,
  parameter int DEADZONE     = 16,
  parameter int SHIFT        = 4,
  parameter int ACCEL_FRAMES = 30,
  parameter int EDGE_MODE    = 0
) (
  input  logic             frame_clk,
  input  logic             Reset,
  joystick_sprite_if.slave js
);

  localparam int                CW       = $clog2(ACCEL_FRAMES + 1);
  localparam logic [CW-1:0]     HOLD_MAX = CW'(ACCEL_FRAMES);
  localparam logic [8:0]        DZ       = 9'(DEADZONE);
  localparam logic signed [11:0] SIZE_S  = 12'(SIZE);

  logic [9:0]    pos_q  [2];
  logic [9:0]    pos_d  [2];
  logic [CW-1:0] hold_q [2];
  logic [CW-1:0] hold_d [2];
  logic [1:0]    dir_q  [2];
  logic [1:0]    dir_d  [2];
  logic          moving_q, moving_d;
  logic [1:0]    hit_q, hit_d;

  logic signed [8:0]  off      [2];
  logic [8:0]         mag      [2];
  logic [8:0]         base     [2];
  logic [1:0]         dir_now  [2];
  logic [11:0]        step_mag [2];
  logic signed [11:0] step     [2];
  logic signed [11:0] next_raw [2];
  logic signed [11:0] next_fix [2];
  logic signed [11:0] ax_max   [2];
  logic [9:0]         ax_ctr   [2];

  always_comb begin
    off[0]    = $signed({1'b0, js.xstick}) - 9'sd128;
    off[1]    = 9'sd128 - $signed({1'b0, js.ystick});
    ax_max[0] = 12'(X_MAX);
    ax_max[1] = 12'(Y_MAX);
    ax_ctr[0] = 10'(X_CENTER);
    ax_ctr[1] = 10'(Y_CENTER);
    moving_d  = 1'b0;
    hit_d     = 2'b00;

    for (int i = 0; i < 2; i++) begin
      // Sign-magnitude keeps left/right speeds symmetric (truncate toward zero).
      mag[i]     = off[i][8] ? 9'(-off[i]) : 9'(off[i]);
      base[i]    = (mag[i] <= DZ) ? 9'd0 : (mag[i] >> SHIFT);
      dir_now[i] = (base[i] == 9'd0) ? 2'b00 : (off[i][8] ? 2'b11 : 2'b01);

      step_mag[i] = {3'b000, base[i]};
      if (js.boost) step_mag[i] = step_mag[i] << 1;
      if (hold_q[i] == HOLD_MAX) step_mag[i] = step_mag[i] << 1;
      step[i] = off[i][8] ? -$signed(step_mag[i]) : $signed(step_mag[i]);

      if (dir_now[i] == 2'b00)
        hold_d[i] = '0;
      else if (dir_now[i] == dir_q[i])
        hold_d[i] = (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + 1'b1;
      else
        hold_d[i] = CW'(1);
      dir_d[i] = dir_now[i];

      next_raw[i] = $signed({2'b00, pos_q[i]}) + step[i];
      next_fix[i] = next_raw[i];
      if (EDGE_MODE == 0) begin
        if (next_raw[i] < SIZE_S) begin
          next_fix[i] = SIZE_S;
          hit_d[i]    = 1'b1;
        end else if (next_raw[i] > ax_max[i] - SIZE_S) begin
          next_fix[i] = ax_max[i] - SIZE_S;
          hit_d[i]    = 1'b1;
        end
      end else begin
        // |step| never exceeds MAX, so one correction is enough.
        if (next_raw[i] < 12'sd0) begin
          next_fix[i] = next_raw[i] + ax_max[i] + 12'sd1;
          hit_d[i]    = 1'b1;
        end else if (next_raw[i] > ax_max[i]) begin
          next_fix[i] = next_raw[i] - ax_max[i] - 12'sd1;
          hit_d[i]    = 1'b1;
        end
      end
      pos_d[i] = 10'(next_fix[i]);
      if (step[i] != 12'sd0) moving_d = 1'b1;
    end

    if (js.recenter) begin
      for (int i = 0; i < 2; i++) begin
        pos_d[i]  = ax_ctr[i];
        hold_d[i] = '0;
        dir_d[i]  = 2'b00;
      end
      moving_d = 1'b0;
      hit_d    = 2'b00;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      pos_q[0]  <= 10'(X_CENTER);
      pos_q[1]  <= 10'(Y_CENTER);
      hold_q[0] <= '0;
      hold_q[1] <= '0;
      dir_q[0]  <= 2'b00;
      dir_q[1]  <= 2'b00;
      moving_q  <= 1'b0;
      hit_q     <= 2'b00;
    end else begin
      pos_q    <= pos_d;
      hold_q   <= hold_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      hit_q    <= hit_d;
    end
  end

  assign js.BallX  = pos_q[0];
  assign js.BallY  = pos_q[1];
  assign js.BallS  = 10'(SIZE);
  assign js.moving = moving_q;
  assign js.hit_x  = hit_q[0];
  assign js.hit_y  = hit_q[1];

endmodule

// File: tb/tb_joystick_sprite.sv
// Bench for joystick_sprite: clamp and wrap instances side by side, directed
// scenarios plus random stimulus against a behavioural position model.
module tb_joystick_sprite;
  localparam int X_MAX = 639, Y_MAX = 479, X_CENTER = 320, Y_CENTER = 240;
  localparam int SIZE = 4, DEADZONE = 16, SHIFT = 4, ACCEL_FRAMES = 30;

  logic frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  logic       Reset = 1'b1;
  logic [7:0] xs = 8'd128, ys = 8'd128;
  logic       bst = 1'b0, rc = 1'b0;

  joystick_sprite_if if_c ();
  joystick_sprite_if if_w ();

  assign if_c.xstick = xs;  assign if_w.xstick = xs;
  assign if_c.ystick = ys;  assign if_w.ystick = ys;
  assign if_c.boost = bst;  assign if_w.boost = bst;
  assign if_c.recenter = rc; assign if_w.recenter = rc;

  joystick_sprite #(.EDGE_MODE(0)) u_clamp (.frame_clk(frame_clk), .Reset(Reset), .js(if_c));
  joystick_sprite #(.EDGE_MODE(1)) u_wrap  (.frame_clk(frame_clk), .Reset(Reset), .js(if_w));

  int n_checks = 0;
  int n_errors = 0;

  // Model state indexed [mode][axis], mode 0 = clamp, 1 = wrap.
  int m_pos  [2][2];
  int m_hold [2][2];
  int m_prev [2][2];
  bit m_mov  [2];
  bit m_hit  [2][2];

  function automatic int base_step(int d);
    int a;
    a = (d < 0) ? -d : d;
    if (a <= DEADZONE) return 0;
    return (d < 0) ? -(a >> SHIFT) : (a >> SHIFT);
  endfunction

  task automatic model_edge();
    int d [2];
    int mx [2];
    int b, s, nxt;
    d[0] = int'(xs) - 128;
    d[1] = 128 - int'(ys);
    mx[0] = X_MAX;
    mx[1] = Y_MAX;
    for (int m = 0; m < 2; m++) begin
      if (Reset || rc) begin
        m_pos[m][0] = X_CENTER;
        m_pos[m][1] = Y_CENTER;
        for (int a = 0; a < 2; a++) begin
          m_hold[m][a] = 0; m_prev[m][a] = 0; m_hit[m][a] = 0;
        end
        m_mov[m] = 0;
      end else begin
        m_mov[m] = 0;
        for (int a = 0; a < 2; a++) begin
          b = base_step(d[a]);
          s = b;
          if (bst) s = s * 2;
          if (m_hold[m][a] == ACCEL_FRAMES) s = s * 2;
          if (b == 0) m_hold[m][a] = 0;
          else if ((b > 0 && m_prev[m][a] > 0) || (b < 0 && m_prev[m][a] < 0))
            m_hold[m][a] = (m_hold[m][a] < ACCEL_FRAMES) ? m_hold[m][a] + 1 : ACCEL_FRAMES;
          else m_hold[m][a] = 1;
          m_prev[m][a] = b;
          if (s != 0) m_mov[m] = 1;
          nxt = m_pos[m][a] + s;
          m_hit[m][a] = 0;
          if (m == 0) begin
            if (nxt < SIZE) begin nxt = SIZE; m_hit[m][a] = 1; end
            else if (nxt > mx[a] - SIZE) begin nxt = mx[a] - SIZE; m_hit[m][a] = 1; end
          end else begin
            if (nxt < 0) begin nxt = nxt + mx[a] + 1; m_hit[m][a] = 1; end
            else if (nxt > mx[a]) begin nxt = nxt - mx[a] - 1; m_hit[m][a] = 1; end
          end
          m_pos[m][a] = nxt;
        end
      end
    end
  endtask

  // One frame: update the model with the inputs present at the edge, then sample after it.
  task automatic frame();
    model_edge();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1; xs = 8'd255; ys = 8'd128; bst = 0; rc = 0;
    frame();
    Reset = 0;
    n_checks++;
    if ({if_c.BallX, if_c.BallY, if_c.BallS, if_c.moving, if_c.hit_x, if_c.hit_y} !==
        {10'd320, 10'd240, 10'd4, 3'b000}) begin
      n_errors++;
      $display("FAIL reset_clamp: got X=%0d Y=%0d S=%0d mv=%b hx=%b hy=%b expected 320 240 4 0 0 0",
               if_c.BallX, if_c.BallY, if_c.BallS, if_c.moving, if_c.hit_x, if_c.hit_y);
    end
    n_checks++;
    if ({if_w.BallX, if_w.BallY, if_w.BallS, if_w.moving, if_w.hit_x, if_w.hit_y} !==
        {10'd320, 10'd240, 10'd4, 3'b000}) begin
      n_errors++;
      $display("FAIL reset_wrap: got X=%0d Y=%0d S=%0d mv=%b hx=%b hy=%b expected 320 240 4 0 0 0",
               if_w.BallX, if_w.BallY, if_w.BallS, if_w.moving, if_w.hit_x, if_w.hit_y);
    end
  endtask

  task automatic test_deadzone();
    xs = 8'd140; ys = 8'd116;
    for (int f = 1; f <= 10; f++) begin
      frame();
      n_checks++;
      if ({if_c.BallX, if_c.BallY, if_c.moving} !== {10'd320, 10'd240, 1'b0}) begin
        n_errors++;
        $display("FAIL deadzone f%0d: got X=%0d Y=%0d mv=%b expected 320 240 0",
                 f, if_c.BallX, if_c.BallY, if_c.moving);
      end
    end
  endtask

  task automatic test_direction();
    logic [9:0] ex, ey;
    xs = 8'd255; ys = 8'd255;
    for (int k = 0; k < 3; k++) begin
      frame();
      ex = 10'(327 + 7 * k);
      ey = 10'(233 - 7 * k);
      n_checks++;
      if ({if_c.BallX, if_c.BallY, if_c.moving} !== {ex, ey, 1'b1}) begin
        n_errors++;
        $display("FAIL direction f%0d: got X=%0d Y=%0d mv=%b expected %0d %0d 1",
                 k + 1, if_c.BallX, if_c.BallY, if_c.moving, ex, ey);
      end
    end
  endtask

  task automatic test_accel();
    Reset = 1; frame(); Reset = 0;
    xs = 8'd255; ys = 8'd128;
    for (int f = 1; f <= 31; f++) begin
      frame();
      if (f == 30) begin
        n_checks++;
        if (if_c.BallX !== 10'd530) begin
          n_errors++; $display("FAIL accel_f30: got %0d expected 530", if_c.BallX);
        end
      end
      if (f == 31) begin
        n_checks++;
        if (if_c.BallX !== 10'd544) begin
          n_errors++; $display("FAIL accel_f31: got %0d expected 544", if_c.BallX);
        end
      end
    end
    xs = 8'd128;
    frame();
    n_checks++;
    if ({if_c.BallX, if_c.moving} !== {10'd544, 1'b0}) begin
      n_errors++; $display("FAIL accel_release: got X=%0d mv=%b expected 544 0", if_c.BallX, if_c.moving);
    end
    xs = 8'd255;
    frame();
    n_checks++;
    if ({if_c.BallX, if_c.moving} !== {10'd551, 1'b1}) begin
      n_errors++; $display("FAIL accel_restart: got X=%0d mv=%b expected 551 1", if_c.BallX, if_c.moving);
    end
  endtask

  task automatic test_clamp();
    int ex;
    Reset = 1; frame(); Reset = 0;
    xs = 8'd0; ys = 8'd128; bst = 0;
    for (int f = 1; f <= 38; f++) begin
      frame();
      ex = (f <= 30) ? 320 - 8 * f : 80 - 16 * (f - 30);
      if (ex < 4) ex = 4;
      n_checks++;
      if ({if_c.BallX, if_c.hit_x} !== {10'(ex), (f >= 35)}) begin
        n_errors++;
        $display("FAIL clamp f%0d: got X=%0d hx=%b expected %0d %0d", f, if_c.BallX, if_c.hit_x, ex, (f >= 35));
      end
    end
  endtask

  task automatic test_wrap_recenter();
    Reset = 1; frame(); Reset = 0;
    bst = 1; xs = 8'd255; ys = 8'd128;
    for (int f = 1; f <= 23; f++) begin
      frame();
      if (f == 22) begin
        n_checks++;
        if ({if_w.BallX, if_w.hit_x} !== {10'd628, 1'b0}) begin
          n_errors++; $display("FAIL wrap_f22: got X=%0d hx=%b expected 628 0", if_w.BallX, if_w.hit_x);
        end
      end
      if (f == 23) begin
        n_checks++;
        if ({if_w.BallX, if_w.hit_x} !== {10'd2, 1'b1}) begin
          n_errors++; $display("FAIL wrap_f23: got X=%0d hx=%b expected 2 1", if_w.BallX, if_w.hit_x);
        end
      end
    end
    rc = 1; frame(); rc = 0;
    n_checks++;
    if ({if_w.BallX, if_w.hit_x, if_w.moving} !== {10'd320, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL recenter: got X=%0d hx=%b mv=%b expected 320 0 0", if_w.BallX, if_w.hit_x, if_w.moving);
    end
    frame();
    n_checks++;
    if ({if_w.BallX, if_w.moving} !== {10'd334, 1'b1}) begin
      n_errors++; $display("FAIL post_recenter: got X=%0d mv=%b expected 334 1", if_w.BallX, if_w.moving);
    end
    bst = 0;
  endtask

  task automatic test_corner();
    Reset = 1; frame(); Reset = 0;
    bst = 1; xs = 8'd255; ys = 8'd0;
    for (int f = 1; f <= 60; f++) frame();
    n_checks++;
    if ({if_c.BallX, if_c.BallY, if_c.hit_x, if_c.hit_y} !== {10'd635, 10'd475, 2'b11}) begin
      n_errors++;
      $display("FAIL corner: got X=%0d Y=%0d hx=%b hy=%b expected 635 475 1 1",
               if_c.BallX, if_c.BallY, if_c.hit_x, if_c.hit_y);
    end
    bst = 0;
  endtask

  task automatic test_random();
    logic [32:0] exp_c, exp_w;
    Reset = 1; frame(); Reset = 0;
    for (int f = 0; f < 800; f++) begin
      if ($urandom_range(0, 30) == 0) xs = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 30) == 0) ys = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 20) == 0) bst = ~bst;
      rc    = ($urandom_range(0, 60) == 0);
      Reset = ($urandom_range(0, 150) == 0);
      frame();
      exp_c = {10'(m_pos[0][0]), 10'(m_pos[0][1]), 10'(SIZE), m_mov[0], m_hit[0][0], m_hit[0][1]};
      exp_w = {10'(m_pos[1][0]), 10'(m_pos[1][1]), 10'(SIZE), m_mov[1], m_hit[1][0], m_hit[1][1]};
      n_checks++;
      if ({if_c.BallX, if_c.BallY, if_c.BallS, if_c.moving, if_c.hit_x, if_c.hit_y} !== exp_c) begin
        n_errors++;
        $display("FAIL random_clamp f%0d: got X=%0d Y=%0d mv=%b hx=%b hy=%b expected X=%0d Y=%0d mv=%b hx=%b hy=%b",
                 f, if_c.BallX, if_c.BallY, if_c.moving, if_c.hit_x, if_c.hit_y,
                 m_pos[0][0], m_pos[0][1], m_mov[0], m_hit[0][0], m_hit[0][1]);
      end
      n_checks++;
      if ({if_w.BallX, if_w.BallY, if_w.BallS, if_w.moving, if_w.hit_x, if_w.hit_y} !== exp_w) begin
        n_errors++;
        $display("FAIL random_wrap f%0d: got X=%0d Y=%0d mv=%b hx=%b hy=%b expected X=%0d Y=%0d mv=%b hx=%b hy=%b",
                 f, if_w.BallX, if_w.BallY, if_w.moving, if_w.hit_x, if_w.hit_y,
                 m_pos[1][0], m_pos[1][1], m_mov[1], m_hit[1][0], m_hit[1][1]);
      end
    end
    Reset = 0; rc = 0;
  endtask

  initial begin
    test_reset();
    test_deadzone();
    test_direction();
    test_accel();
    test_clamp();
    test_wrap_recenter();
    test_corner();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/joystick_sprite.md
# joystick_sprite

Per-frame sprite position integrator driven by the GameCube controller's analog stick; parametrised successor of the single-ball mover. Converts 8-bit offset-binary stick axes into signed per-frame steps with deadzone, speed scaling, boost and hold-acceleration. Integrates them into a screen position with selectable clamp or wrap edge handling. Sits between the controller reader and the VGA sprite/color mapper; one update per frame edge.

## Interface
- X_MAX, 639: rightmost pixel column.
- Y_MAX, 479: bottom pixel row.
- X_CENTER, 320: reset/recenter X.
- Y_CENTER, 240: reset/recenter Y.
- SIZE, 4: sprite half-size, driven on BallS.
- DEADZONE, 16: axis offsets with |d| <= DEADZONE are treated as 0.
- SHIFT, 4: speed divisor; |step| = |d| >> SHIFT.
- ACCEL_FRAMES, 30: consecutive same-direction frames before step doubles.
- EDGE_MODE, 0: 0 = clamp to [SIZE, MAX-SIZE]; 1 = wrap modulo MAX+1.
- frame_clk  in  1  sole clock; one rising edge per video frame.
- Reset  in  1  synchronous, active-high.
- xstick  in  8  stick X, offset binary, 128 = centre, 255 = full right.
- ystick  in  8  stick Y, offset binary, 128 = centre, 255 = full up.
- boost  in  1  doubles step while high.
- recenter  in  1  sampled at edge; returns sprite to centre.
- BallX  out  10  sprite centre X.
- BallY  out  10  sprite centre Y.
- BallS  out  10  constant SIZE.
- moving  out  1  a nonzero step was applied this frame.
- hit_x, hit_y  out  1  clamp or wrap occurred on that axis this frame.

## Operation
- Offsets, 9-bit signed: dx = xstick - 128 in [-128,127]; dy = 128 - ystick in [-127,128]. Stick up yields negative dy, so screen Y decreases.
- Deadzone: |d| <= DEADZONE gives d = 0.
- Base step = sign(d) * (|d| >> SHIFT). This is sign-magnitude, truncating toward zero, so left and right speeds are symmetric.
- Hold counter per axis, 0..ACCEL_FRAMES, saturating:
  - Increments on every frame whose base step is nonzero with the same sign as the previous frame's base step.
  - Loads 1 on a sign change or when starting from zero.
  - Clears on a zero step.
- Scale: step <<= 1 if boost; step <<= 1 again if the counter value before update equals ACCEL_FRAMES. Maximum |step| = 4 * (128 >> SHIFT).
- Integration uses 12-bit signed arithmetic: next = pos + step.
- EDGE_MODE 0 (clamp): next < SIZE gives SIZE; next > MAX-SIZE gives MAX-SIZE. hit is asserted in any frame a limit was applied, including repeated pushes into the edge.
- EDGE_MODE 1 (wrap): next < 0 gives next + MAX+1; next > MAX gives next - (MAX+1). hit is asserted in the wrap frame. One correction suffices because |step| <= MAX.
- Priority at each edge: Reset > recenter > motion.
  - Recenter loads the centre values, clears both hold counters and forces moving/hit to 0.
- Axes are fully independent, so simultaneous hits on X and Y are both reported.

## Timing
- All outputs registered.
- Reset values: BallX = X_CENTER, BallY = Y_CENTER, BallS = SIZE, moving = 0, hit_x = hit_y = 0, hold counters = 0, previous-sign registers = 0.
- Latency: inputs sampled at edge k are reflected on outputs after edge k, i.e. one frame. No input registering; upstream holds sticks stable across the edge.
- Reset or recenter asserted mid-motion takes effect at the next edge. Motion resumes from the centre at the first edge after deassertion, with the counters starting from 0.
- moving, hit_x and hit_y are per-frame levels, valid for exactly the frame following the edge that produced them.

## Test plan
- Reset: assert Reset for one edge with xstick=255 -> BallX=320, BallY=240, BallS=4, moving=0, hits=0.
- Deadzone: xstick=140, ystick=116 for 10 frames -> position unchanged, moving=0 throughout.
- Direction/speed: xstick=255, ystick=255, 3 frames -> BallX 327, 334, 341; BallY 233, 226, 219; moving=1.
- Acceleration: xstick=255, ystick=128 held -> BallX=530 after frame 30, 544 after frame 31 (step 14). Releasing to 128 for one frame, then 255 again -> step returns to 7.
- Clamp (EDGE_MODE=0): xstick=0 held from reset -> BallX=80 after frame 30, then 64, 48, 32, 16. Frame 35 gives BallX=4 with hit_x=1, and hit_x stays 1 while held.
- Wrap + recenter (EDGE_MODE=1): boost=1, xstick=255 -> frame 22 BallX=628, frame 23 BallX=2 with hit_x=1. Then recenter=1 for one edge -> BallX=320, hit_x=0, and the next frame step is 14, not 28.
